// File: rtl/sram_like_responder_pkg.sv
// Shared types and constants for the sram-like responder and its response FIFO.
package sram_like_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WEN_W  = 4;

    // Transfer-size encoding of sram_size (informational only)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Capture stage holding the request issued to the RAM last cycle
    typedef struct packed {
        logic valid;
        logic is_write;
    } p1_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// Synchronous FIFO holding responses that could not be returned the cycle they arrived.
module resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty     = (count == '0);
        full      = (count == CNT_W'(DEPTH));
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        head_data = mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like request interface: issues requests to a
// one-cycle-latency synchronous RAM and returns in-order data_ok responses.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RAM_AW     = 16,
    parameter int unsigned ADDR_DELAY = 0,
    parameter int unsigned RESP_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sram_en,
    input  logic              sram_wr,
    input  logic [1:0]        sram_size,
    input  logic [WEN_W-1:0]  sram_wen,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_wdata,
    output logic              sram_addr_ok,
    output logic              sram_data_ok,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              ram_en,
    output logic [WEN_W-1:0]  ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned OUT_W = $clog2(DEPTH) + 1;
    localparam int unsigned AD_W  = cnt_w(ADDR_DELAY + 1);
    localparam int unsigned RD_W  = cnt_w(RESP_DELAY + 1);

    logic [OUT_W-1:0]  outstanding;
    logic [AD_W-1:0]   addr_wait;
    logic [RD_W-1:0]   wait_cnt;
    p1_t               p1;

    logic              accept;
    logic [DATA_W-1:0] p1_data;
    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [OUT_W-1:0]  fifo_count;

    // Accept and RAM issue are combinational from sram_en; reset forces them low
    always_comb begin
        accept       = sram_en && !reset && (outstanding < OUT_W'(DEPTH)) && (addr_wait == '0);
        sram_addr_ok = accept;
        ram_en       = accept;
        ram_addr     = accept ? sram_addr[RAM_AW+1:2] : '0;
        ram_wdata    = accept ? sram_wdata : '0;
        ram_wen      = (accept && sram_wr) ? sram_wen : '0;
    end

    // Head is the oldest buffered response, else the one arriving from the RAM
    always_comb begin
        p1_data      = p1.is_write ? '0 : ram_rdata;
        head_valid   = !fifo_empty || p1.valid;
        head_data    = !fifo_empty ? fifo_head : p1_data;
        sram_data_ok = head_valid && (wait_cnt == RD_W'(RESP_DELAY));
        sram_rdata   = head_valid ? head_data : '0;
        fifo_pop     = sram_data_ok && !fifo_empty;
        fifo_push    = p1.valid && !(fifo_empty && sram_data_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            addr_wait   <= '0;
            wait_cnt    <= '0;
            p1          <= '0;
        end else begin
            if (accept && !sram_data_ok)      outstanding <= outstanding + OUT_W'(1);
            else if (!accept && sram_data_ok) outstanding <= outstanding - OUT_W'(1);

            if (accept)                addr_wait <= AD_W'(ADDR_DELAY);
            else if (addr_wait != '0)  addr_wait <= addr_wait - AD_W'(1);

            p1.valid    <= accept;
            p1.is_write <= accept && sram_wr;

            // A p1 head moved into the FIFO is the same entry, so its wait keeps counting
            if (!head_valid || sram_data_ok) wait_cnt <= '0;
            else                             wait_cnt <= wait_cnt + RD_W'(1);
        end
    end

    resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (p1_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    logic unused_bits;
    assign unused_bits = ^{sram_size, sram_addr[ADDR_W-1:RAM_AW+2], sram_addr[1:0],
                           fifo_full, fifo_count};

endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench: three responder configurations, each backed by a small RAM model.
module tb_sram_like_responder;

    localparam int unsigned N = 3;

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    function automatic int unsigned depth_of(input int i);
        return (i == 1) ? 2 : 4;
    endfunction
    function automatic int unsigned ad_of(input int i);
        return (i == 2) ? 2 : 0;
    endfunction
    function automatic int unsigned rd_of(input int i);
        return (i == 1) ? 3 : ((i == 2) ? 8 : 0);
    endfunction
    function automatic logic [31:0] init_word(input int i);
        if (i == 'h10) return 32'h2402000A;
        if (i == 'h20) return 32'h11223344;
        return 32'hA500_0000 | 32'(i);
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;

    logic        sram_en      [N];
    logic        sram_wr      [N];
    logic [1:0]  sram_size    [N];
    logic [3:0]  sram_wen     [N];
    logic [31:0] sram_addr    [N];
    logic [31:0] sram_wdata   [N];
    logic        sram_addr_ok [N];
    logic        sram_data_ok [N];
    logic [31:0] sram_rdata   [N];
    logic        ram_en       [N];
    logic [3:0]  ram_wen      [N];
    logic [15:0] ram_addr     [N];
    logic [31:0] ram_wdata    [N];

    exp_t        exp_q[$];
    int          last_dok [N];
    int          acc_cyc[$];
    logic [31:0] stim_addr[$];
    logic [31:0] stim_exp[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [31:0] mem [256];
        logic [31:0] rd_q;

        sram_like_responder #(
            .DEPTH      (depth_of(g)),
            .RAM_AW     (16),
            .ADDR_DELAY (ad_of(g)),
            .RESP_DELAY (rd_of(g))
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .sram_en      (sram_en[g]),
            .sram_wr      (sram_wr[g]),
            .sram_size    (sram_size[g]),
            .sram_wen     (sram_wen[g]),
            .sram_addr    (sram_addr[g]),
            .sram_wdata   (sram_wdata[g]),
            .sram_addr_ok (sram_addr_ok[g]),
            .sram_data_ok (sram_data_ok[g]),
            .sram_rdata   (sram_rdata[g]),
            .ram_en       (ram_en[g]),
            .ram_wen      (ram_wen[g]),
            .ram_addr     (ram_addr[g]),
            .ram_wdata    (ram_wdata[g]),
            .ram_rdata    (rd_q)
        );

        // Synchronous RAM model with one-cycle read latency and byte lanes
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                rd_q <= '0;
            end else if (ram_en[g]) begin
                rd_q <= mem[ram_addr[g][7:0]];
                for (int b = 0; b < 4; b++)
                    if (ram_wen[g][b]) mem[ram_addr[g][7:0]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response time model: head appears after accept or after the previous response
    task automatic push_exp(input int inst, input logic [31:0] data);
        exp_t e;
        int   head_t;
        head_t = (cyc + 1 > last_dok[inst] + 1) ? cyc + 1 : last_dok[inst] + 1;
        e.inst = inst;
        e.data = data;
        e.cyc  = head_t + int'(rd_of(inst));
        last_dok[inst] = e.cyc;
        exp_q.push_back(e);
    endtask

    // Hold sram_en high until every request in stim_addr is accepted
    task automatic burst(input int inst, input logic wr, input logic [3:0] wen,
                         input logic [31:0] wdata);
        int k = 0;
        int budget = 0;
        int n = stim_addr.size();
        acc_cyc.delete();
        @(posedge clk); #1;
        sram_en[inst]    = 1'b1;
        sram_wr[inst]    = wr;
        sram_wen[inst]   = wen;
        sram_wdata[inst] = wdata;
        sram_addr[inst]  = stim_addr[0];
        while (k < n && budget < 200) begin
            @(negedge clk);
            if (sram_addr_ok[inst]) begin
                check("ram_en_on_accept", 32'(ram_en[inst]), 32'd1);
                check("ram_addr", 32'(ram_addr[inst]), 32'(stim_addr[k][17:2]));
                check("ram_wen", 32'(ram_wen[inst]), wr ? 32'(wen) : 32'd0);
                acc_cyc.push_back(cyc);
                push_exp(inst, stim_exp[k]);
                k++;
            end else begin
                check("ram_en_idle", 32'(ram_en[inst]), 32'd0);
            end
            @(posedge clk); #1;
            budget++;
            if (k < n) sram_addr[inst] = stim_addr[k];
        end
        sram_en[inst] = 1'b0;
        if (k < n) check("accept_timeout", 32'(k), 32'(n));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check("idle_data_ok", 32'(sram_data_ok[g]), 32'd0);
            check("idle_rdata", sram_rdata[g], 32'd0);
        end
    endtask

    // Monitor: every data_ok must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < N; g++) begin
            if (sram_data_ok[g]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_data_ok: inst %0d rdata 0x%08h at cycle %0d, none expected",
                             g, sram_rdata[g], cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("data_ok_inst", 32'(g), 32'(e.inst));
                    check("rdata", sram_rdata[g], e.data);
                    check("data_ok_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int off2[4];
        int off3[3];
        for (int i = 0; i < N; i++) begin
            sram_en[i] = 1'b0; sram_wr[i] = 1'b0; sram_size[i] = 2'd2;
            sram_wen[i] = '0; sram_addr[i] = '0; sram_wdata[i] = '0;
            last_dok[i] = 0;
        end

        // Reset values, with a live request held on the bus
        repeat (2) @(posedge clk); #1;
        sram_en[0] = 1'b1; sram_wr[0] = 1'b1; sram_wen[0] = 4'hF;
        sram_addr[0] = 32'h40; sram_wdata[0] = 32'hDEADBEEF;
        #1;
        check("rst_addr_ok", 32'(sram_addr_ok[0]), 32'd0);
        check("rst_data_ok", 32'(sram_data_ok[0]), 32'd0);
        check("rst_rdata", sram_rdata[0], 32'd0);
        check("rst_ram_en", 32'(ram_en[0]), 32'd0);
        check("rst_ram_wen", 32'(ram_wen[0]), 32'd0);
        check("rst_ram_addr", 32'(ram_addr[0]), 32'd0);
        check("rst_ram_wdata", ram_wdata[0], 32'd0);
        sram_en[0] = 1'b0; sram_wr[0] = 1'b0; sram_wen[0] = '0;
        reset = 1'b0;

        // Single read of word 0x10
        stim_addr = '{32'h40};
        stim_exp  = '{32'h2402000A};
        burst(0, 1'b0, 4'h0, 32'h0);
        drain(20);

        // Four back-to-back reads
        stim_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        stim_exp  = '{32'hA5000000, 32'hA5000001, 32'hA5000002, 32'hA5000003};
        burst(0, 1'b0, 4'h0, 32'h0);
        for (int i = 1; i < 4; i++) check("b2b_accept_gap", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
        drain(20);

        // DEPTH=2, RESP_DELAY=3: accept reopens the cycle after each data_ok
        off2 = '{0, 1, 5, 9};
        burst(1, 1'b0, 4'h0, 32'h0);
        for (int i = 1; i < 4; i++) check("full_accept_offset", 32'(acc_cyc[i] - acc_cyc[0]), 32'(off2[i]));
        drain(40);

        // Partial write then read back
        stim_addr = '{32'h80};
        stim_exp  = '{32'h0};
        burst(0, 1'b1, 4'b0011, 32'hAABBCCDD);
        drain(20);
        stim_addr = '{32'h80};
        stim_exp  = '{32'h1122CCDD};
        burst(0, 1'b0, 4'h0, 32'h0);
        drain(20);

        // ADDR_DELAY=2: accepts three cycles apart, then reset before any response
        stim_addr = '{32'h0, 32'h4, 32'h8};
        stim_exp  = '{32'hA5000000, 32'hA5000001, 32'hA5000002};
        off3 = '{0, 3, 6};
        burst(2, 1'b0, 4'h0, 32'h0);
        for (int i = 1; i < 3; i++) check("addr_delay_offset", 32'(acc_cyc[i] - acc_cyc[0]), 32'(off3[i]));
        reset = 1'b1;
        sram_en[2] = 1'b1; sram_addr[2] = 32'h10;
        #1;
        check("midrst_addr_ok", 32'(sram_addr_ok[2]), 32'd0);
        check("midrst_data_ok", 32'(sram_data_ok[2]), 32'd0);
        check("midrst_rdata", sram_rdata[2], 32'd0);
        check("midrst_ram_en", 32'(ram_en[2]), 32'd0);
        check("midrst_ram_addr", 32'(ram_addr[2]), 32'd0);
        sram_en[2] = 1'b0;
        exp_q.delete();
        last_dok[2] = 0;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 4 == 0) check("post_rst_quiet", 32'(sram_data_ok[2]), 32'd0);
        end

        // Fresh read after reset completes normally
        stim_addr = '{32'hC};
        stim_exp  = '{32'hA5000003};
        burst(2, 1'b0, 4'h0, 32'h0);
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
